// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte slave sampled by i_clk: 2-FF synchronised inputs, RX strobe, TX holding register.
// Optional feature macro SPI_MISO_OE_EN adds o_spi_miso_oe for a top-level tristate buffer.
module spi_slave_byte (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_spi_sclk,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  output logic       o_tx_ready
`ifdef SPI_MISO_OE_EN
  ,
  output logic       o_spi_miso_oe
`endif
);

  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] cs_n_sync_q, cs_n_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic       sel_q, sel_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       load_pend_q, load_pend_d;
  logic [7:0] hold_q, hold_d;
  logic       tx_ready_q, tx_ready_d;
  logic [7:0] tx_shift_q, tx_shift_d;

  logic sclk_rise, sclk_fall, cs_active, cs_fall, mosi_s;
  logic active, load_evt, shift_evt;

  // Bit [1] is the synchronised level, bit [2] the previous level for edge detection.
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_active = ~cs_n_sync_q[1];
  assign cs_fall   = cs_n_sync_q[2] & ~cs_n_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];

  // sel_q arms the shifter only after a CS falling edge has been seen since reset.
  assign active    = sel_q & cs_active;
  assign load_evt  = cs_fall | (active & sclk_fall & load_pend_q);
  assign shift_evt = active & sclk_fall & ~load_pend_q;

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch can leave a latch behind.
    sclk_sync_d = {sclk_sync_q[1:0], i_spi_sclk};
    cs_n_sync_d = {cs_n_sync_q[1:0], i_spi_cs_n};
    mosi_sync_d = {mosi_sync_q[0], i_spi_mosi};
    sel_d       = cs_fall | (sel_q & cs_active);
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    load_pend_d = load_pend_q;
    hold_d      = hold_q;
    tx_ready_d  = tx_ready_q;
    tx_shift_d  = tx_shift_q;

    if (!active) begin
      bit_cnt_d   = 3'd0;
      rx_shift_d  = 8'h00;
      load_pend_d = 1'b0;
    end else if (sclk_rise) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_byte_d   = {rx_shift_q[6:0], mosi_s};
        rx_valid_d  = 1'b1;
        load_pend_d = 1'b1;
      end
    end else if (sclk_fall && load_pend_q) begin
      load_pend_d = 1'b0;
    end

    // Capture decisions look at tx_ready_q, i.e. the holding state before this cycle.
    if (tx_ready_q && i_tx_dv) begin
      hold_d     = i_tx_byte;
      tx_ready_d = 1'b0;
    end

    if (!cs_active) begin
      tx_shift_d = 8'h00;
    end else if (load_evt) begin
      if (!tx_ready_q) begin
        tx_shift_d = hold_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d = 8'h00;
      end
    end else if (shift_evt) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync_q <= 3'b000;
      cs_n_sync_q <= 3'b111;
      mosi_sync_q <= 2'b00;
      sel_q       <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      load_pend_q <= 1'b0;
      hold_q      <= 8'h00;
      tx_ready_q  <= 1'b1;
      tx_shift_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking only here, so every flop samples the pre-edge values.
      sclk_sync_q <= sclk_sync_d;
      cs_n_sync_q <= cs_n_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sel_q       <= sel_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      load_pend_q <= load_pend_d;
      hold_q      <= hold_d;
      tx_ready_q  <= tx_ready_d;
      tx_shift_q  <= tx_shift_d;
    end
  end

  assign o_spi_miso = tx_shift_q[7];
  assign o_rx_byte  = rx_byte_q;
  assign o_rx_valid = rx_valid_q;
  assign o_tx_ready = tx_ready_q;

`ifdef SPI_MISO_OE_EN
  logic oe_q, oe_d;
  assign oe_d = cs_active;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) oe_q <= 1'b0;
    else          oe_q <= oe_d;
  end

  assign o_spi_miso_oe = oe_q;
`endif

endmodule

// File: tb/tb_spi_slave_byte.sv
// Self-checking bench for spi_slave_byte: SPI master tasks, byte-level TX/RX model, per-cycle monitor.
module tb_spi_slave_byte;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_spi_sclk;
  logic       i_spi_cs_n;
  logic       i_spi_mosi;
  logic       o_spi_miso;
  logic [7:0] o_rx_byte;
  logic       o_rx_valid;
  logic [7:0] i_tx_byte;
  logic       i_tx_dv;
  logic       o_tx_ready;
`ifdef SPI_MISO_OE_EN
  logic       o_spi_miso_oe;
`endif

  spi_slave_byte dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_spi_sclk (i_spi_sclk),
    .i_spi_cs_n (i_spi_cs_n),
    .i_spi_mosi (i_spi_mosi),
    .o_spi_miso (o_spi_miso),
    .o_rx_byte  (o_rx_byte),
    .o_rx_valid (o_rx_valid),
    .i_tx_byte  (i_tx_byte),
    .i_tx_dv    (i_tx_dv),
    .o_tx_ready (o_tx_ready)
`ifdef SPI_MISO_OE_EN
    ,
    .o_spi_miso_oe (o_spi_miso_oe)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;

  // Byte-level model: expected RX strobes, holding register, byte now in the TX shifter.
  logic [7:0] q_rx[$];
  logic       m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic [7:0] m_cur  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_load();
    logic [7:0] v;
    v = m_full ? m_hold : 8'h00;
    m_full = 1'b0;
    return v;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic issue_dv(input logic [7:0] val);
    check("tx_ready_pre_dv", 32'(o_tx_ready), 32'(!m_full));
    i_tx_byte = val;
    i_tx_dv   = 1'b1;
    @(negedge i_clk);
    i_tx_dv   = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_hold = val;
    end
    check("tx_ready_post_dv", 32'(o_tx_ready), 32'd0);
  endtask

  task automatic cs_assert(input int lead);
    @(negedge i_clk);
    i_spi_cs_n = 1'b0;
    m_cur = model_load();
    wait_cycles(lead);
  endtask

  task automatic cs_deassert();
    wait_cycles(6);
    i_spi_cs_n = 1'b1;
    wait_cycles(8);
    i_spi_mosi = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] mo, input int half, input logic dv_en,
                           input logic [7:0] dv_val, output logic [7:0] mi);
    q_rx.push_back(mo);
    mi = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      i_spi_mosi = mo[i];
      if (dv_en && i == 4) issue_dv(dv_val);
      wait_cycles(half);
      mi[i] = o_spi_miso;
      i_spi_sclk = 1'b1;
      wait_cycles(half);
      i_spi_sclk = 1'b0;
    end
    check("miso_byte", 32'(mi), 32'(m_cur));
    m_cur = model_load();
  endtask

  task automatic xfer_partial(input logic [7:0] mo, input int k, input int half);
    for (int i = 7; i > 7 - k; i--) begin
      i_spi_mosi = mo[i];
      wait_cycles(half);
      i_spi_sclk = 1'b1;
      wait_cycles(half);
      i_spi_sclk = 1'b0;
    end
  endtask

  // Per-cycle monitor: strobes against the model queue, o_rx_byte hold, idle MISO.
  initial begin
    logic [7:0] last_rx;
    logic       prev_valid;
    int         cs_hi_cnt;
    int         cs_lo_cnt;
    last_rx = 8'h00;
    prev_valid = 1'b0;
    cs_hi_cnt = 0;
    cs_lo_cnt = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n !== 1'b1) begin
        last_rx = 8'h00;
        prev_valid = 1'b0;
        cs_hi_cnt = 0;
        cs_lo_cnt = 0;
      end else begin
        if (i_spi_cs_n) begin cs_hi_cnt++; cs_lo_cnt = 0; end
        else            begin cs_lo_cnt++; cs_hi_cnt = 0; end
        if (o_rx_valid) begin
          n_strobe++;
          if (q_rx.size() == 0) check("rx_unexpected_strobe", 32'(o_rx_valid), 32'd0);
          else                  check("rx_byte", 32'(o_rx_byte), 32'(q_rx.pop_front()));
          check("rx_valid_width", 32'(prev_valid), 32'd0);
        end else begin
          check("rx_byte_hold", 32'(o_rx_byte), 32'(last_rx));
        end
        if (cs_hi_cnt >= 5) check("miso_idle", 32'(o_spi_miso), 32'd0);
`ifdef SPI_MISO_OE_EN
        if (cs_hi_cnt >= 5) check("oe_idle", 32'(o_spi_miso_oe), 32'd0);
        if (cs_lo_cnt >= 5) check("oe_active", 32'(o_spi_miso_oe), 32'd1);
`endif
        last_rx = o_rx_byte;
        prev_valid = o_rx_valid;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] mi;
    int         s0;
    int         half;
    int         nb;

    i_rst_n    = 1'b0;
    i_spi_sclk = 1'b0;
    i_spi_cs_n = 1'b1;
    i_spi_mosi = 1'b0;
    i_tx_byte  = 8'h00;
    i_tx_dv    = 1'b0;
    wait_cycles(3);
    check("reset_miso", 32'(o_spi_miso), 32'd0);
    check("reset_rx_byte", 32'(o_rx_byte), 32'h00);
    check("reset_rx_valid", 32'(o_rx_valid), 32'd0);
    check("reset_tx_ready", 32'(o_tx_ready), 32'd1);
    i_rst_n = 1'b1;
    wait_cycles(5);

    // Two bytes at SCLK = i_clk/8 with nothing loaded: MISO idles at 0x00.
    cs_assert(6);
    xfer_byte(8'h12, 4, 1'b0, 8'h00, mi);
    check("miso_unloaded_0", 32'(mi), 32'h00);
    xfer_byte(8'h34, 4, 1'b0, 8'h00, mi);
    check("miso_unloaded_1", 32'(mi), 32'h00);
    cs_deassert();

    // 0xA5 before CS, 0x5A mid-byte, then nothing for the third byte.
    issue_dv(8'hA5);
    check("ready_low_after_load", 32'(o_tx_ready), 32'd0);
    cs_assert(6);
    check("ready_high_after_csfall", 32'(o_tx_ready), 32'd1);
    xfer_byte(8'h11, 4, 1'b1, 8'h5A, mi);
    check("miso_a5", 32'(mi), 32'hA5);
    xfer_byte(8'h22, 4, 1'b0, 8'h00, mi);
    check("miso_5a", 32'(mi), 32'h5A);
    check("ready_high_after_5a", 32'(o_tx_ready), 32'd1);
    xfer_byte(8'h33, 4, 1'b0, 8'h00, mi);
    check("miso_empty", 32'(mi), 32'h00);
    check("ready_stays_high", 32'(o_tx_ready), 32'd1);
    cs_deassert();

    // Abort after 5 bits of 0xFF: no strobe, holding (0x3C) retained for the next frame.
    s0 = n_strobe;
    cs_assert(6);
    issue_dv(8'h3C);
    xfer_partial(8'hFF, 5, 4);
    cs_deassert();
    check("ready_retained_after_abort", 32'(o_tx_ready), 32'd0);
    cs_assert(6);
    xfer_byte(8'h81, 4, 1'b0, 8'h00, mi);
    check("miso_retained_3c", 32'(mi), 32'h3C);
    cs_deassert();
    check("abort_strobe_count", 32'(n_strobe - s0), 32'd1);

    // i_tx_dv lands in the CS-fall load cycle (two syncs, then the detect cycle).
    @(negedge i_clk);
    i_spi_cs_n = 1'b0;
    m_cur = model_load();
    wait_cycles(2);
    i_tx_byte = 8'hC3;
    i_tx_dv   = 1'b1;
    @(negedge i_clk);
    i_tx_dv   = 1'b0;
    m_full = 1'b1;
    m_hold = 8'hC3;
    check("ready_low_after_collision", 32'(o_tx_ready), 32'd0);
    wait_cycles(4);
    xfer_byte(8'hAA, 4, 1'b0, 8'h00, mi);
    check("miso_collision_zero", 32'(mi), 32'h00);
    xfer_byte(8'h55, 4, 1'b0, 8'h00, mi);
    check("miso_collision_c3", 32'(mi), 32'hC3);
    cs_deassert();

    // Asynchronous reset in the middle of a byte with holding full.
    cs_assert(6);
    issue_dv(8'h99);
    xfer_partial(8'hE0, 3, 4);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midreset_miso", 32'(o_spi_miso), 32'd0);
    check("midreset_rx_byte", 32'(o_rx_byte), 32'h00);
    check("midreset_rx_valid", 32'(o_rx_valid), 32'd0);
    check("midreset_tx_ready", 32'(o_tx_ready), 32'd1);
    m_full = 1'b0;
    q_rx.delete();
    i_spi_cs_n = 1'b1;
    i_spi_sclk = 1'b0;
    wait_cycles(3);
    i_rst_n = 1'b1;
    wait_cycles(4);
    check("post_reset_tx_ready", 32'(o_tx_ready), 32'd1);

    // SCLK toggling with CS inactive must not produce a strobe.
    s0 = n_strobe;
    i_spi_mosi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_cycles(4);
      i_spi_sclk = 1'b1;
      wait_cycles(4);
      i_spi_sclk = 1'b0;
    end
    i_spi_mosi = 1'b0;
    wait_cycles(6);
    check("no_strobe_cs_idle", 32'(n_strobe - s0), 32'd0);

    // Randomised frames.
    for (int f = 0; f < 14; f++) begin
      half = int'($urandom_range(6, 4));
      if ($urandom_range(1, 0) == 1) issue_dv(8'($urandom));
      cs_assert(half + 2);
      nb = int'($urandom_range(3, 1));
      for (int b = 0; b < nb; b++)
        xfer_byte(8'($urandom), half, ($urandom_range(2, 0) == 0), 8'($urandom), mi);
      if ($urandom_range(3, 0) == 0)
        xfer_partial(8'($urandom), int'($urandom_range(7, 1)), half);
      cs_deassert();
    end

    wait_cycles(10);
    check("rx_queue_drained", 32'(q_rx.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_byte.md
SPI_SLAVE_BYTE -- requirements
Module: spi_slave_byte

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: i_clk, i_rst_n.
REQ-002 Ports SHALL be, in order:
- i_clk  in  1  system clock
- i_rst_n  in  1  async reset, active-low
- i_spi_sclk  in  1  SPI clock, mode 0, asynchronous to i_clk
- i_spi_cs_n  in  1  chip select, active-low
- i_spi_mosi  in  1  serial data in, MSB first
- o_spi_miso  out  1  serial data out, MSB first
- o_rx_byte  out  8  last complete received byte
- o_rx_valid  out  1  one-cycle strobe, o_rx_byte updated
- i_tx_byte  in  8  next byte to transmit
- i_tx_dv  in  1  load strobe for i_tx_byte
- o_tx_ready  out  1  transmit holding register empty
- o_spi_miso_oe  out  1  MISO output enable (only with SPI_MISO_OE_EN)

Function
REQ-003 SHALL pass i_spi_sclk, i_spi_cs_n and i_spi_mosi through 2-FF synchronisers, then detect SCLK edges with a third register.
REQ-004 SHALL require SCLK high and low phases of at least 3 i_clk cycles each; faster SCLK is unsupported.
REQ-005 SHALL shift synchronised MOSI into an 8-bit RX shift register on each detected SCLK rising edge while CS is active; 3-bit bit counter increments per rising edge.
REQ-006 On the 8th rising edge SHALL set o_rx_byte = {rx_shift[6:0], mosi}, pulse o_rx_valid for exactly one cycle and wrap the bit counter to 0.
REQ-007 SHALL hold o_rx_byte stable between strobes; no ack, each new byte overwrites it.
REQ-008 Transmit holding register: i_tx_dv while o_tx_ready=1 SHALL capture i_tx_byte and drop o_tx_ready the next cycle; i_tx_dv while o_tx_ready=0 SHALL be ignored.
REQ-009 Byte-load event SHALL occur (a) on the synchronised CS falling edge, and (b) on the first SCLK falling edge after a byte completes (REQ-006).
REQ-010 At a byte-load event SHALL copy holding into the TX shift register if full (then o_tx_ready=1 next cycle), else load 0x00; o_spi_miso presents bit 7.
REQ-011 On every other SCLK falling edge with CS active SHALL shift TX left by one and present the new bit 7 on o_spi_miso.
REQ-012 Simultaneous i_tx_dv and byte-load in one cycle SHALL use the holding state before that cycle: if empty, send 0x00 and capture the new byte into holding.
REQ-013 CS deasserted mid-byte SHALL clear the bit counter and discard the partial RX byte without a strobe; holding register contents and o_tx_ready SHALL be retained.
REQ-014 While CS is inactive SCLK edges SHALL be ignored and o_spi_miso SHALL be 0.

Reset
REQ-015 On i_rst_n low SHALL asynchronously clear all registers: o_rx_byte=0x00, o_rx_valid=0, o_spi_miso=0, o_tx_ready=1, holding and shift registers 0, bit counter 0, synchronisers to idle (SCLK 0, CS_n 1, MOSI 0).
REQ-016 On reset release SHALL ignore any SCLK activity until a synchronised CS falling edge is seen.

Configuration
REQ-017 SPI_MISO_OE_EN defined: SHALL add port o_spi_miso_oe = synchronised CS active, registered, reset 0, for a top-level tristate buffer.
REQ-018 SPI_MISO_OE_EN undefined: port o_spi_miso_oe SHALL not exist and o_spi_miso SHALL be driven at all times per REQ-014.

Verification
REQ-019 Reset asserted mid-transfer -> all outputs at reset values in the same cycle; o_tx_ready=1.
REQ-020 CS low, MOSI bytes 0x12 then 0x34 at SCLK=i_clk/8 -> two one-cycle o_rx_valid strobes carrying 0x12 then 0x34.
REQ-021 i_tx_dv with 0xA5 before CS falls, 0x5A loaded after o_tx_ready returns high -> MISO carries 0xA5 then 0x5A, MSB first; o_tx_ready low then high around each load.
REQ-022 No byte loaded for the second byte -> MISO carries 0x00; o_tx_ready stays 1.
REQ-023 CS raised after 5 bits of 0xFF, then byte 0x81 sent -> no strobe for the partial byte, single strobe with 0x81.
REQ-024 i_tx_dv 0xC3 asserted in the byte-load cycle with holding empty -> current byte sends 0x00, next byte sends 0xC3.
